// File: rtl/sobel_frame_writer.sv
// sobel_frame_writer: writes a full output frame, zero border plus saturated interior gradients
// Ports: start kicks a frame; in_valid/in_ready/in_data carry interior gradients in raster order;
// wr_en/wr_addr/wr_data drive the output RAM one pixel per write; busy marks RUN; done pulses with the last write.
module sobel_frame_writer #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int GW    = 11,
  parameter int DW    = 8,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [GW-1:0] in_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done
);
  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    RUN    = 1'b1;
  localparam logic [AW-1:0] LAST_I = AW'(IMG_H - 1);
  localparam logic [AW-1:0] LAST_J = AW'(IMG_W - 1);
  localparam logic [GW-1:0] MAXV   = GW'((1 << DW) - 1);
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d, p_q, p_d;
  logic          wr_en_q, wr_en_d, done_q, done_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d, sat;
  logic          run, border, last, step, ld;
  always_comb begin
    run       = state_q == RUN;
    border    = (i_q == '0) || (i_q == LAST_I) || (j_q == '0) || (j_q == LAST_J);
    last      = (i_q == LAST_I) && (j_q == LAST_J);
    step      = run && (border || in_valid);
    ld        = !run && start;
    sat       = (in_data > MAXV) ? '1 : in_data[DW-1:0];
    state_d   = ld ? RUN : (step && last) ? IDLE : state_q;
    j_d       = ld ? '0 : step ? ((j_q == LAST_J) ? '0 : j_q + AW'(1)) : j_q;
    i_d       = ld ? '0 : (step && j_q == LAST_J) ? (last ? '0 : i_q + AW'(1)) : i_q;
    p_d       = ld ? '0 : step ? p_q + AW'(1) : p_q;
    wr_en_d   = step;
    wr_addr_d = step ? p_q : wr_addr_q;
    wr_data_d = step ? (border ? '0 : sat) : wr_data_q;
    done_d    = step && last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      p_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      p_q       <= p_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end
  assign in_ready = run && !border;
  assign busy     = run;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
endmodule

// File: tb/tb_sobel_frame_writer.sv
// tb_sobel_frame_writer: directed frames against a positional model plus a small 4x3 instance
module tb_sobel_frame_writer;
  localparam int W = 64;
  localparam int H = 64;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, wr_en, busy, done;
  logic [10:0] in_data;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic s_start, s_valid, s_ready, s_wr_en, s_busy, s_done;
  logic [10:0] s_data;
  logic [3:0]  s_addr;
  logic [7:0]  s_wdata;
  int vectors = 0;
  int miscompares = 0;
  int tbl [6] = '{0, 255, 256, 300, 2040, 2047};
  always #5 clk = ~clk;
  sobel_frame_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );
  sobel_frame_writer #(.IMG_W(4), .IMG_H(3), .GW(11), .DW(8), .AW(4)) sdut (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .wr_en(s_wr_en), .wr_addr(s_addr), .wr_data(s_wdata), .busy(s_busy), .done(s_done)
  );
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic bit interior(input int p);
    return (p / W != 0) && (p / W != H - 1) && (p % W != 0) && (p % W != W - 1);
  endfunction
  function automatic int satf(input int x);
    return (x > 255) ? 255 : x;
  endfunction
  bit m_run;
  int m_pos, cons, e_addr, e_data;
  bit e_wr, e_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0; m_pos <= 0; cons <= 0; e_wr <= 0; e_done <= 0; e_addr <= 0; e_data <= 0;
    end else begin
      e_wr <= 0;
      e_done <= 0;
      if (!m_run) begin
        if (start) begin m_run <= 1; m_pos <= 0; cons <= 0; end
      end else if (!interior(m_pos) || in_valid) begin
        e_wr <= 1;
        e_addr <= m_pos;
        e_data <= interior(m_pos) ? satf(int'(in_data)) : 0;
        e_done <= m_pos == N - 1;
        m_pos <= m_pos + 1;
        if (m_pos == N - 1) m_run <= 0;
        if (interior(m_pos)) cons <= cons + 1;
      end
    end
  end
  int cyc = 0;
  int nwr = 0, nrdy = 0, ndone = 0, done_addr = -1;
  logic [7:0] mem [N];
  int wt [N];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_en", int'(wr_en), int'(e_wr));
      if (e_wr) begin
        check("wr_addr", int'(wr_addr), e_addr);
        check("wr_data", int'(wr_data), e_data);
        check("done", int'(done), int'(e_done));
      end else check("done_idle", int'(done), 0);
      check("busy", int'(busy), int'(m_run));
      check("in_ready", int'(in_ready), int'(m_run && interior(m_pos)));
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
        wt[wr_addr] <= cyc;
        nwr <= nwr + 1;
        if (done) done_addr <= int'(wr_addr);
      end
      if (in_ready) nrdy <= nrdy + 1;
      if (done) ndone <= ndone + 1;
    end
  end
  int s_cons = 0, s_nwr = 0, s_done_addr = -1;
  logic [7:0] smem [16];
  int s_cnt [16];
  always @(posedge clk) if (s_valid && s_ready) s_cons <= s_cons + 1;
  always @(negedge clk) if (rst_n && s_wr_en) begin
    smem[s_addr] <= s_wdata;
    s_cnt[s_addr] <= s_cnt[s_addr] + 1;
    s_nwr <= s_nwr + 1;
    if (s_done) s_done_addr <= int'(s_addr);
  end
  task automatic reset_checks(input string tag);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
  endtask
  task automatic run(input int mode, output bit hit);
    int s65 = 0, s126 = 0;
    hit = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start = 0;
      if (done) begin hit = 1; return; end
      in_valid = 1;
      in_data = 11'd100;
      if (mode == 0 && wr_en && wr_addr == 12'd500) start = 1;
      if (mode == 1) begin
        in_data = 11'(tbl[cons % 6]);
        if (m_pos == 65 && s65 < 10) begin in_valid = 0; s65++; end
        if (m_pos == 126 && s126 < 10) begin in_valid = 0; s126++; end
        if (wr_en && wr_addr == 12'd1000) begin
          #2 rst_n = 0;
          #1 reset_checks("midreset");
          @(negedge clk);
          #2 rst_n = 1;
          return;
        end
      end
      if (mode == 2) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_data = 11'($urandom_range(0, 2047));
      end
    end
  endtask
  initial begin
    int w0, r0, d0, nbad;
    bit hd;
    rst_n = 0; start = 0; in_valid = 0; in_data = 0;
    s_start = 0; s_valid = 0; s_data = 0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    #2 rst_n = 1;
    @(negedge clk);
    w0 = nwr; r0 = nrdy; d0 = ndone;
    start = 1;
    run(0, hd);
    #1;
    check("f1_done_seen", int'(hd), 1);
    check("f1_writes", nwr - w0, 4096);
    check("f1_ready_cycles", nrdy - r0, 3844);
    check("f1_done_pulses", ndone - d0, 1);
    check("f1_done_addr", done_addr, 4095);
    check("f1_span", wt[4095] - wt[0], 4095);
    check("f1_px0", int'(mem[0]), 0);
    check("f1_px65", int'(mem[65]), 100);
    check("f1_px_row63", int'(mem[63 * 64 + 5]), 0);
    check("f1_px_col63", int'(mem[5 * 64 + 63]), 0);
    check("f1_px4095", int'(mem[4095]), 0);
    nbad = 0;
    for (int a = 0; a < N; a++) if (int'(mem[a]) != (interior(a) ? 100 : 0)) nbad++;
    check("f1_pixels_bad", nbad, 0);
    @(negedge clk);
    start = 1;
    run(1, hd);
    check("sat_0", int'(mem[65]), 0);
    check("sat_255", int'(mem[66]), 255);
    check("sat_256", int'(mem[67]), 255);
    check("sat_300", int'(mem[68]), 255);
    check("sat_2040", int'(mem[69]), 255);
    check("sat_2047", int'(mem[70]), 255);
    check("stall_65_gap", wt[65] - wt[64], 11);
    check("stall_126_gap", wt[126] - wt[125], 11);
    check("stall_127_next", wt[127] - wt[126], 1);
    @(negedge clk);
    w0 = nwr; d0 = ndone;
    start = 1;
    run(2, hd);
    start = 1;
    #1;
    check("f3_done_seen", int'(hd), 1);
    check("f3_writes", nwr - w0, 4096);
    check("f3_done_pulses", ndone - d0, 1);
    w0 = nwr;
    run(0, hd);
    #1;
    check("f4_done_seen", int'(hd), 1);
    check("f4_writes", nwr - w0, 4096);
    check("f4_done_addr", done_addr, 4095);
    @(negedge clk);
    s_start = 1;
    hd = 0;
    for (int c = 0; c < 100 && !hd; c++) begin
      @(negedge clk);
      s_start = 0;
      hd = s_done;
      s_valid = 1;
      s_data = (s_cons == 0) ? 11'd7 : 11'd9;
    end
    @(negedge clk);
    check("s_done_seen", int'(hd), 1);
    check("s_writes", s_nwr, 12);
    check("s_done_addr", s_done_addr, 11);
    check("s_consumed", s_cons, 2);
    for (int a = 0; a < 12; a++) begin
      check($sformatf("s_px%0d", a), int'(smem[a]), (a == 5) ? 7 : (a == 6) ? 9 : 0);
      check($sformatf("s_cnt%0d", a), s_cnt[a], 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
